// File: rtl/ahb_master.sv
// AHB-Lite initiator: command/handshake front end to single and INCR bursts
// with overlapped address/data phases, wait states, ERROR and 1KB splitting.
module ahb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              hsel,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_INCR = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE, S_NSEQ, S_SEQ, S_LAST, S_ERRW
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              hsel_q, hsel_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [2:0]        sz;
  logic [4:0]        len;
  logic [2:0]        burst;
  logic              dph;
  logic              fin;
  logic              fail;
  logic [ADDR_W-1:0] nxt;

  always_comb begin
    sz  = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
    len = (cmd_len == 5'd0) ? 5'd1 :
          (cmd_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : cmd_len;
    case (len)
      5'd1:    burst = 3'b000;
      5'd4:    burst = 3'b011;
      5'd8:    burst = 3'b101;
      5'd16:   burst = 3'b111;
      default: burst = B_INCR;
    endcase
  end

  // A data phase is outstanding whenever a previous address phase completed
  assign dph = (state_q == S_SEQ) || (state_q == S_LAST);
  assign nxt = haddr_q + (ADDR_W'(1) << hsize_q);

  assign wr_pop = hwrite_q & htrans_q[1] & hready & ~(dph & hresp);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    cmd_ready_d = cmd_ready_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fin         = 1'b0;
    fail        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_NSEQ;
          cmd_ready_d = 1'b0;
          hsel_d      = 1'b1;
          htrans_d    = T_NSEQ;
          haddr_d     = cmd_addr;
          hwrite_d    = cmd_write;
          hsize_d     = sz;
          hburst_d    = burst;
          cnt_d       = len - 5'd1;
        end
      end
      S_ERRW: begin
        if (hready) begin
          fin  = 1'b1;
          fail = 1'b1;
        end
      end
      default: begin
        if (dph && hresp) begin
          htrans_d = T_IDLE;
          state_d  = S_ERRW;
          if (hready) begin
            fin  = 1'b1;
            fail = 1'b1;
          end
        end else begin
          if (dph && hready && !hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = hrdata;
          end
          if (hready) begin
            if (state_q == S_LAST) begin
              fin = 1'b1;
            end else begin
              if (hwrite_q) hwdata_d = wr_data;
              if (cnt_q == 5'd0) begin
                htrans_d = T_IDLE;
                state_d  = S_LAST;
              end else begin
                haddr_d = nxt;
                cnt_d   = cnt_q - 5'd1;
                state_d = S_SEQ;
                if (nxt[9:0] == 10'd0) begin
                  htrans_d = T_NSEQ;
                  hburst_d = B_INCR;
                end else begin
                  htrans_d = T_SEQ;
                end
              end
            end
          end
        end
      end
    endcase
    if (fin) begin
      state_d     = S_IDLE;
      htrans_d    = T_IDLE;
      hsel_d      = 1'b0;
      cmd_ready_d = 1'b1;
      done_d      = 1'b1;
      err_d       = fail;
    end
  end

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= T_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd2;
      hburst_q    <= 3'b000;
      hwdata_q    <= '0;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hburst_q    <= hburst_d;
      hwdata_q    <= hwdata_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign hsel      = hsel_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = hburst_q;
  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master with a small AHB slave model
// (programmable wait states and two-cycle ERROR on a chosen beat).
module tb_ahb_master;

  logic        clk;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [4:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  ahb_master #(.ADDR_W(32), .DATA_W(32), .MAX_LEN(16)) dut (
    .clk(clk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .haddr(haddr),
    .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slave model
  logic [31:0] mem [0:1023];
  logic [31:0] wsrc [0:15];
  int          wait_n;
  int          err_beat;
  logic        dp_act, dp_write, dp_err;
  logic [31:0] dp_addr;
  int          wleft, nbeat;
  logic [3:0]  pcnt;

  assign hready  = !dp_act || (wleft == 0);
  assign hresp   = dp_act && dp_err;
  assign hrdata  = (dp_act && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;
  assign wr_data = wsrc[pcnt];

  always @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      dp_act   <= 1'b0;
      dp_write <= 1'b0;
      dp_err   <= 1'b0;
      dp_addr  <= '0;
      wleft    <= 0;
      nbeat    <= 0;
      pcnt     <= '0;
    end else begin
      if (wr_pop) pcnt <= pcnt + 4'd1;
      if (dp_act && wleft != 0) begin
        wleft <= wleft - 1;
      end else begin
        if (dp_act && dp_write && !dp_err)
          mem[dp_addr[11:2]] <= hwdata;
        if (hsel && htrans[1]) begin
          dp_act   <= 1'b1;
          dp_addr  <= haddr;
          dp_write <= hwrite;
          dp_err   <= (nbeat == err_beat);
          wleft    <= (nbeat == err_beat) ? 1 : wait_n;
          nbeat    <= nbeat + 1;
        end else begin
          dp_act <= 1'b0;
        end
      end
      if (done) begin
        nbeat <= 0;
        pcnt  <= '0;
      end
    end
  end

  // monitor logs
  logic [31:0] ap_addr [0:255];
  logic [1:0]  ap_tr   [0:255];
  logic [2:0]  ap_bu   [0:255];
  logic [31:0] ap_cyc  [0:255];
  logic [31:0] rd_log  [0:255];
  logic [1:0]  tr_log  [0:4095];
  logic [31:0] hw_log  [0:4095];
  logic [31:0] cyc;
  int          ap_n, rd_n, pop_n, done_n;
  logic        done_err;
  logic [31:0] done_cyc, last_dp_cyc, err_cyc;

  initial cyc = '0;

  always @(negedge clk) begin
    cyc <= cyc + 32'd1;
    tr_log[cyc[11:0]] <= htrans;
    hw_log[cyc[11:0]] <= hwdata;
    if (hresetn) begin
      if (htrans[1] && hready) begin
        ap_addr[ap_n[7:0]] <= haddr;
        ap_tr[ap_n[7:0]]   <= htrans;
        ap_bu[ap_n[7:0]]   <= hburst;
        ap_cyc[ap_n[7:0]]  <= cyc;
        ap_n <= ap_n + 1;
      end
      if (wr_pop) pop_n <= pop_n + 1;
      if (rd_valid) begin
        rd_log[rd_n[7:0]] <= rd_data;
        rd_n <= rd_n + 1;
      end
      if (done) begin
        done_err <= err;
        done_cyc <= cyc;
        done_n   <= done_n + 1;
      end
      if (dp_act && hready) last_dp_cyc <= cyc;
      if (hresp && !hready) err_cyc <= cyc;
    end
  end

  int nchk;
  int nerr;
  int a0, r0, p0, d0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    a0 = ap_n;
    r0 = rd_n;
    p0 = pop_n;
    d0 = done_n;
  endtask

  task automatic run(input logic wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [4:0] ln);
    snap();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_len   = ln;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    for (int i = 0; i < 300; i++) begin
      if (done_n != d0) break;
      @(negedge clk);
      #1;
    end
    chk("cmd_done", done_n - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0; nerr = 0;
    ap_n = 0; rd_n = 0; pop_n = 0; done_n = 0;
    done_err = 1'b0; done_cyc = '0; last_dp_cyc = '0; err_cyc = '0;
    hresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = 3'd2; cmd_len = 5'd1;
    wait_n = 0; err_beat = -1;
    for (int i = 0; i < 16; i++) wsrc[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hsel", hsel, 1'b0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hsize", hsize, 3'd2);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    hresetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // single write with one wait state
    wait_n = 1;
    wsrc[0] = 32'hDEADBEEF;
    run(1'b1, 32'h10, 3'd2, 5'd1);
    chk("w1_naddr", ap_n - a0, 1);
    chk("w1_addr", ap_addr[a0], 32'h10);
    chk("w1_trans", ap_tr[a0], 2'b10);
    chk("w1_burst", ap_bu[a0], 3'b000);
    chk("w1_hwd_w", hw_log[ap_cyc[a0][11:0] + 12'd1], 32'hDEADBEEF);
    chk("w1_hwd_r", hw_log[ap_cyc[a0][11:0] + 12'd2], 32'hDEADBEEF);
    chk("w1_pops", pop_n - p0, 1);
    chk("w1_err", done_err, 1'b0);
    chk("w1_mem", mem[4], 32'hDEADBEEF);

    // single read, len 0 treated as 1
    run(1'b0, 32'h10, 3'd2, 5'd0);
    chk("r1_nrd", rd_n - r0, 1);
    chk("r1_data", rd_log[r0], 32'hDEADBEEF);
    chk("r1_burst", ap_bu[a0], 3'b000);

    // INCR4 write, no waits
    wait_n = 0;
    wsrc[0] = 32'h11; wsrc[1] = 32'h22;
    wsrc[2] = 32'h33; wsrc[3] = 32'h44;
    run(1'b1, 32'h100, 3'd2, 5'd4);
    chk("w4_naddr", ap_n - a0, 4);
    chk("w4_a0", ap_addr[a0], 32'h100);
    chk("w4_a1", ap_addr[a0+1], 32'h104);
    chk("w4_a2", ap_addr[a0+2], 32'h108);
    chk("w4_a3", ap_addr[a0+3], 32'h10C);
    chk("w4_t0", ap_tr[a0], 2'b10);
    chk("w4_t1", ap_tr[a0+1], 2'b11);
    chk("w4_t3", ap_tr[a0+3], 2'b11);
    chk("w4_burst", ap_bu[a0], 3'b011);
    chk("w4_pops", pop_n - p0, 4);
    chk("w4_done_lat", done_cyc - last_dp_cyc, 1);
    chk("w4_mem0", mem[32'h40], 32'h11);
    chk("w4_mem3", mem[32'h43], 32'h44);

    // 1KB crossing: fill then read back with size clamped 3->2
    wsrc[0] = 32'hA1; wsrc[1] = 32'hA2;
    wsrc[2] = 32'hA3; wsrc[3] = 32'hA4;
    run(1'b1, 32'h3F8, 3'd2, 5'd4);
    run(1'b0, 32'h3F8, 3'd3, 5'd4);
    chk("x_a1", ap_addr[a0+1], 32'h3FC);
    chk("x_a2", ap_addr[a0+2], 32'h400);
    chk("x_a3", ap_addr[a0+3], 32'h404);
    chk("x_t1", ap_tr[a0+1], 2'b11);
    chk("x_t2", ap_tr[a0+2], 2'b10);
    chk("x_t3", ap_tr[a0+3], 2'b11);
    chk("x_b0", ap_bu[a0], 3'b011);
    chk("x_b2", ap_bu[a0+2], 3'b001);
    chk("x_nrd", rd_n - r0, 4);
    chk("x_rd0", rd_log[r0], 32'hA1);
    chk("x_rd2", rd_log[r0+2], 32'hA3);
    chk("x_rd3", rd_log[r0+3], 32'hA4);

    // INCR8 write, ERROR on third beat
    err_beat = 2;
    run(1'b1, 32'h200, 3'd2, 5'd8);
    chk("e_burst", ap_bu[a0], 3'b101);
    chk("e_naddr", ap_n - a0, 3);
    chk("e_pops", pop_n - p0, 3);
    chk("e_idle", tr_log[err_cyc[11:0] + 12'd1], 2'b00);
    chk("e_err", done_err, 1'b1);
    chk("e_ready", cmd_ready, 1'b1);
    err_beat = -1;

    // reset during beat 2 of an INCR4 read
    wait_n = 2;
    snap();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    cmd_addr = 32'h100; cmd_size = 3'd2; cmd_len = 5'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (ap_n - a0 >= 2) break;
      @(negedge clk);
      #1;
    end
    chk("rr_reached", (ap_n - a0 >= 2) ? 1 : 0, 1);
    hresetn = 1'b0;
    #1;
    chk("rr_htrans", htrans, 2'b00);
    chk("rr_hsel", hsel, 1'b0);
    chk("rr_haddr", haddr, 32'h0);
    chk("rr_hburst", hburst, 3'b000);
    chk("rr_ready", cmd_ready, 1'b1);
    chk("rr_rdv", rd_valid, 1'b0);
    chk("rr_done", done, 1'b0);
    repeat (2) @(negedge clk);
    hresetn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rr_nodone", done_n - d0, 0);
    wait_n = 0;
    run(1'b0, 32'h104, 3'd2, 5'd1);
    chk("rr_rd", rd_log[r0], 32'h22);
    chk("rr_err", done_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
